// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter (instruction fetch, data load/store) in front of a
//   single SPI memory controller. One transaction is in flight at a time.
//   Ties alternate between requesters, starting with data after reset. A busy
//   transaction that sees no completion within TIMEOUT_CYCLES is aborted and
//   reported as an error.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   f_req, f_addr               fetch request (always a 4-byte read)
//   f_done                      one-cycle fetch completion pulse
//   d_req, d_addr, d_num_bytes  data request (size 1, 2 or 4 bytes)
//   d_is_write, d_wdata         store flag and store value
//   d_done                      one-cycle data completion pulse
//   err                         marks the current done pulse as failed
//   rdata                       registered read data, valid with a done pulse
//   mem_start                   level start to the memory controller
//   mem_addr, mem_num_bytes,
//   mem_is_write, mem_wdata     latched transaction fields
//   mem_done, mem_rdata         controller completion level and read data

module mem_arbiter #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_done,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_num_bytes,
   input  logic        d_is_write,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_start,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_num_bytes,
   output logic        mem_is_write,
   output logic [31:0] mem_wdata,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
   typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

   state_t      state, state_nx;
   grant_t      last_grant, last_grant_nx;
   logic [7:0]  cnt, cnt_nx;

   logic        f_done_nx, d_done_nx, err_nx, start_nx;
   logic [31:0] rdata_nx, addr_nx, wdata_nx;
   logic [2:0]  num_bytes_nx;
   logic        is_write_nx;

   logic        pick_data, pick_fetch, size_ok;

   // Data wins when it is the only requester, or on a tie when fetch went last.
   assign pick_data  = d_req && (!f_req || (last_grant == GRANT_FETCH));
   assign pick_fetch = f_req && !pick_data;
   assign size_ok    = (d_num_bytes == 3'd1) || (d_num_bytes == 3'd2) ||
                       (d_num_bytes == 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= GRANT_FETCH;
         cnt           <= 8'd0;
         f_done        <= 1'b0;
         d_done        <= 1'b0;
         err           <= 1'b0;
         rdata         <= 32'd0;
         mem_start     <= 1'b0;
         mem_addr      <= 32'd0;
         mem_num_bytes <= 3'd0;
         mem_is_write  <= 1'b0;
         mem_wdata     <= 32'd0;
      end else begin
         state         <= state_nx;
         last_grant    <= last_grant_nx;
         cnt           <= cnt_nx;
         f_done        <= f_done_nx;
         d_done        <= d_done_nx;
         err           <= err_nx;
         rdata         <= rdata_nx;
         mem_start     <= start_nx;
         mem_addr      <= addr_nx;
         mem_num_bytes <= num_bytes_nx;
         mem_is_write  <= is_write_nx;
         mem_wdata     <= wdata_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      cnt_nx        = cnt;
      f_done_nx     = 1'b0;
      d_done_nx     = 1'b0;
      err_nx        = 1'b0;
      rdata_nx      = rdata;
      start_nx      = mem_start;
      addr_nx       = mem_addr;
      num_bytes_nx  = mem_num_bytes;
      is_write_nx   = mem_is_write;
      wdata_nx      = mem_wdata;

      case (state)
         IDLE: begin
            if (pick_data) begin
               last_grant_nx = GRANT_DATA;
               if (size_ok) begin
                  addr_nx      = d_addr;
                  num_bytes_nx = d_num_bytes;
                  is_write_nx  = d_is_write;
                  wdata_nx     = d_wdata;
                  start_nx     = 1'b1;
                  cnt_nx       = 8'd0;
                  state_nx     = BUSY;
               end else begin
                  // Illegal size never reaches the controller.
                  d_done_nx = 1'b1;
                  err_nx    = 1'b1;
                  rdata_nx  = 32'd0;
                  state_nx  = RELEASE;
               end
            end else if (pick_fetch) begin
               last_grant_nx = GRANT_FETCH;
               addr_nx       = f_addr;
               num_bytes_nx  = 3'd4;
               is_write_nx   = 1'b0;
               wdata_nx      = 32'd0;
               start_nx      = 1'b1;
               cnt_nx        = 8'd0;
               state_nx      = BUSY;
            end
         end

         BUSY: begin
            // Completion takes priority over a timeout in the same cycle.
            if (mem_done) begin
               rdata_nx  = mem_rdata;
               start_nx  = 1'b0;
               f_done_nx = (last_grant == GRANT_FETCH);
               d_done_nx = (last_grant == GRANT_DATA);
               state_nx  = RELEASE;
            end else if (cnt == (TIMEOUT_CYCLES - 8'd1)) begin
               rdata_nx  = 32'd0;
               start_nx  = 1'b0;
               f_done_nx = (last_grant == GRANT_FETCH);
               d_done_nx = (last_grant == GRANT_DATA);
               err_nx    = 1'b1;
               state_nx  = RELEASE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end

         RELEASE: begin
            // Holds start low for a cycle so the controller returns to idle.
            start_nx = 1'b0;
            state_nx = IDLE;
         end

         default: begin
            start_nx = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: single fetch, illegal data size, store with
//   field stability, timeout and last-cycle completion, reset mid-transaction,
//   and tie alternation between requesters.

module tb_mem_arbiter;

   localparam logic [7:0] TMO = 8'd30;

   logic        clk;
   logic        rst_n;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_done;
   logic        d_req;
   logic [31:0] d_addr;
   logic [2:0]  d_num_bytes;
   logic        d_is_write;
   logic [31:0] d_wdata;
   logic        d_done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_start;
   logic [31:0] mem_addr;
   logic [2:0]  mem_num_bytes;
   logic        mem_is_write;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .f_req        (f_req),
      .f_addr       (f_addr),
      .f_done       (f_done),
      .d_req        (d_req),
      .d_addr       (d_addr),
      .d_num_bytes  (d_num_bytes),
      .d_is_write   (d_is_write),
      .d_wdata      (d_wdata),
      .d_done       (d_done),
      .err          (err),
      .rdata        (rdata),
      .mem_start    (mem_start),
      .mem_addr     (mem_addr),
      .mem_num_bytes(mem_num_bytes),
      .mem_is_write (mem_is_write),
      .mem_wdata    (mem_wdata),
      .mem_done     (mem_done),
      .mem_rdata    (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_f_done"}, {31'd0, f_done}, 32'd0);
      chk({tag, "_d_done"}, {31'd0, d_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      f_req = 1'b0; f_addr = 32'd0;
      d_req = 1'b0; d_addr = 32'd0; d_num_bytes = 3'd0; d_is_write = 1'b0; d_wdata = 32'd0;
      mem_done = 1'b0; mem_rdata = 32'd0;
      #1 rst_n = 1'b0;
      tick(); tick();
      // reset state
      chk("rst_start", {31'd0, mem_start}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_nb", {29'd0, mem_num_bytes}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk_idle_outs("rst");
      rst_n = 1'b1;
      tick();
      chk("idle_start", {31'd0, mem_start}, 32'd0);

      // single fetch, completion after 20 busy cycles
      f_req = 1'b1; f_addr = 32'h0000_0100;
      tick();
      chk("f_start", {31'd0, mem_start}, 32'd1);
      chk("f_addr", mem_addr, 32'h0000_0100);
      chk("f_nb", {29'd0, mem_num_bytes}, 32'd4);
      chk("f_wr", {31'd0, mem_is_write}, 32'd0);
      chk("f_wdata", mem_wdata, 32'd0);
      for (int i = 0; i < 19; i++) begin
         tick();
         chk("f_busy_done", {31'd0, f_done}, 32'd0);
      end
      chk("f_busy_start", {31'd0, mem_start}, 32'd1);
      mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("f_done", {31'd0, f_done}, 32'd1);
      chk("f_d_done", {31'd0, d_done}, 32'd0);
      chk("f_err", {31'd0, err}, 32'd0);
      chk("f_rdata", rdata, 32'hDEAD_BEEF);
      chk("f_rel_start", {31'd0, mem_start}, 32'd0);
      f_req = 1'b0; mem_done = 1'b0;
      tick();
      chk_idle_outs("f_after");
      chk("f_after_start", {31'd0, mem_start}, 32'd0);
      tick();
      chk("f_idle_start", {31'd0, mem_start}, 32'd0);

      // illegal data size: error completion without touching the controller
      d_req = 1'b1; d_addr = 32'h0000_0040; d_num_bytes = 3'd3; d_is_write = 1'b0;
      tick();
      chk("bad_d_done", {31'd0, d_done}, 32'd1);
      chk("bad_err", {31'd0, err}, 32'd1);
      chk("bad_rdata", rdata, 32'd0);
      chk("bad_start", {31'd0, mem_start}, 32'd0);
      chk("bad_f_done", {31'd0, f_done}, 32'd0);
      d_req = 1'b0;
      tick();
      chk_idle_outs("bad_after");
      chk("bad_after_start", {31'd0, mem_start}, 32'd0);
      tick();

      // 2-byte store; fields must hold while requester inputs wander
      d_req = 1'b1; d_addr = 32'h0000_0200; d_num_bytes = 3'd2; d_is_write = 1'b1; d_wdata = 32'h0000_1234;
      tick();
      chk("st_start", {31'd0, mem_start}, 32'd1);
      chk("st_addr", mem_addr, 32'h0000_0200);
      d_addr = 32'hFFFF_0000; d_num_bytes = 3'd4; d_is_write = 1'b0; d_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("st_hold_wdata", mem_wdata, 32'h0000_1234);
         chk("st_hold_nb", {29'd0, mem_num_bytes}, 32'd2);
      end
      chk("st_hold_wr", {31'd0, mem_is_write}, 32'd1);
      chk("st_hold_addr", mem_addr, 32'h0000_0200);
      mem_done = 1'b1; mem_rdata = 32'h0000_A5A5;
      tick();
      chk("st_d_done", {31'd0, d_done}, 32'd1);
      chk("st_err", {31'd0, err}, 32'd0);
      chk("st_rdata", rdata, 32'h0000_A5A5);
      chk("st_start_low", {31'd0, mem_start}, 32'd0);
      d_req = 1'b0; mem_done = 1'b0;
      tick();
      chk_idle_outs("st_after");
      chk("st_after_start", {31'd0, mem_start}, 32'd0);
      tick();

      // timeout: TMO busy cycles without completion
      f_req = 1'b1; f_addr = 32'h0000_0300;
      tick();
      chk("to_start", {31'd0, mem_start}, 32'd1);
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk("to_busy_done", {31'd0, f_done}, 32'd0);
      end
      chk("to_busy_start", {31'd0, mem_start}, 32'd1);
      tick();
      chk("to_f_done", {31'd0, f_done}, 32'd1);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_rdata", rdata, 32'd0);
      chk("to_start_low", {31'd0, mem_start}, 32'd0);
      f_req = 1'b0;
      tick();
      chk_idle_outs("to_after");
      tick();

      // completion in the last busy cycle wins over timeout
      f_req = 1'b1; f_addr = 32'h0000_0304;
      tick();
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("late_no_done", {31'd0, f_done}, 32'd0);
      mem_done = 1'b1; mem_rdata = 32'h0000_600D;
      tick();
      chk("late_f_done", {31'd0, f_done}, 32'd1);
      chk("late_err", {31'd0, err}, 32'd0);
      chk("late_rdata", rdata, 32'h0000_600D);
      f_req = 1'b0; mem_done = 1'b0;
      tick();
      tick();

      // reset in the middle of a busy data read
      d_req = 1'b1; d_addr = 32'h0000_0400; d_num_bytes = 3'd4; d_is_write = 1'b0; d_wdata = 32'd0;
      tick();
      chk("rb_start", {31'd0, mem_start}, 32'd1);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rb_start_drop", {31'd0, mem_start}, 32'd0);
      chk("rb_addr", mem_addr, 32'd0);
      chk("rb_rdata", rdata, 32'd0);
      chk_idle_outs("rb");
      rst_n = 1'b1;
      tick();
      chk("rb_regrant", {31'd0, mem_start}, 32'd1);
      chk("rb_regrant_addr", mem_addr, 32'h0000_0400);
      chk("rb_no_done", {31'd0, d_done}, 32'd0);
      mem_done = 1'b1; mem_rdata = 32'h0000_0011;
      tick();
      chk("rb_d_done", {31'd0, d_done}, 32'd1);
      chk("rb_rdata2", rdata, 32'h0000_0011);
      d_req = 1'b0; mem_done = 1'b0;
      tick();
      tick();

      // tie from reset: data first, then alternation
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      f_req = 1'b1; f_addr = 32'h0000_0500;
      d_req = 1'b1; d_addr = 32'h0000_0600; d_num_bytes = 3'd4; d_is_write = 1'b0;
      tick();
      chk("tie1_addr", mem_addr, 32'h0000_0600);
      mem_done = 1'b1; mem_rdata = 32'h0000_0001;
      tick();
      chk("tie1_d_done", {31'd0, d_done}, 32'd1);
      chk("tie1_f_done", {31'd0, f_done}, 32'd0);
      mem_done = 1'b0;
      tick();
      chk("tie1_rel_start", {31'd0, mem_start}, 32'd0);
      tick();
      chk("tie2_addr", mem_addr, 32'h0000_0500);
      chk("tie2_nb", {29'd0, mem_num_bytes}, 32'd4);
      chk("tie2_start", {31'd0, mem_start}, 32'd1);
      mem_done = 1'b1; mem_rdata = 32'h0000_0002;
      tick();
      chk("tie2_f_done", {31'd0, f_done}, 32'd1);
      chk("tie2_d_done", {31'd0, d_done}, 32'd0);
      mem_done = 1'b0;
      tick(); tick();
      chk("tie3_addr", mem_addr, 32'h0000_0600);
      mem_done = 1'b1; mem_rdata = 32'h0000_0003;
      tick();
      chk("tie3_d_done", {31'd0, d_done}, 32'd1);
      f_req = 1'b0; d_req = 1'b0; mem_done = 1'b0;
      tick(); tick();
      chk_idle_outs("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
